// File: rtl/host_bus_receiver.sv
// host_bus_receiver: synchronises the MCU two-phase write bus into clk10
// and decodes address/value pairs into run, duty and per-speaker delay registers.
`timescale 1ns/1ps
module host_bus_receiver #(
   parameter int         NUM_SPEAKERS = 37,
   parameter logic [5:0] DELAY_BASE   = 6'h10,
   parameter logic [5:0] DUTY_RESET   = 6'h08
) (
   input  logic                      clk10,
   input  logic                      reset_n,
   input  logic                      sync,
   input  logic                      address,
   input  logic [5:0]                data,
   output logic                      run,
   output logic [5:0]                duty,
   output logic [6*NUM_SPEAKERS-1:0] delays,
   output logic                      runStart,
   output logic                      protoError
);
   localparam int DW = 6*NUM_SPEAKERS;
   typedef enum logic {WAIT_ADDR, WAIT_DATA} state_t;
   state_t          state_q, state_d;
   logic [2:0]      sync_q;
   logic [1:0]      addr_q;
   logic [5:0]      data1_q, data2_q;
   logic [5:0]      regaddr_q, regaddr_d;
   logic            run_q, run_d;
   logic [5:0]      duty_q, duty_d;
   logic [DW-1:0]   delays_q, delays_d;
   logic            runstart_q, runstart_d;
   logic            perr_q, perr_d;
   logic            rise;
   logic            hit;
   // all three inputs share the same two-stage depth so address/data stay aligned with sync
   always_ff @(posedge clk10 or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         addr_q  <= '0;
         data1_q <= '0;
         data2_q <= '0;
      end else begin
         sync_q  <= {sync_q[1:0], sync};
         addr_q  <= {addr_q[0], address};
         data1_q <= data;
         data2_q <= data1_q;
      end
   end
   assign rise = sync_q[1] & ~sync_q[2];
   always_ff @(posedge clk10 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= WAIT_ADDR;
         regaddr_q  <= '0;
         run_q      <= 1'b0;
         duty_q     <= DUTY_RESET;
         delays_q   <= '0;
         runstart_q <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         regaddr_q  <= regaddr_d;
         run_q      <= run_d;
         duty_q     <= duty_d;
         delays_q   <= delays_d;
         runstart_q <= runstart_d;
         perr_q     <= perr_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      regaddr_d  = regaddr_q;
      run_d      = run_q;
      duty_d     = duty_q;
      delays_d   = delays_q;
      runstart_d = 1'b0;
      perr_d     = perr_q;
      hit        = 1'b0;
      if (rise) begin
         if (addr_q[1]) begin
            regaddr_d = data2_q;
            state_d   = WAIT_DATA;
            perr_d    = perr_q | (state_q == WAIT_DATA);
         end else if (state_q == WAIT_ADDR) begin
            perr_d = 1'b1;
         end else begin
            state_d = WAIT_ADDR;
            if (regaddr_q == 6'h00) begin
               perr_d = 1'b0;
            end else if (regaddr_q == 6'h01) begin
               run_d      = data2_q[0];
               runstart_d = data2_q[0] & ~run_q;
            end else if (regaddr_q == 6'h02) begin
               duty_d = data2_q;
            end else begin
               for (int n = 0; n < NUM_SPEAKERS; n++) begin
                  if (regaddr_q == DELAY_BASE + 6'(n)) begin
                     hit                 = 1'b1;
                     delays_d[6*n +: 6]  = data2_q;
                  end
               end
               perr_d = perr_q | ~hit;
            end
         end
      end
   end
   assign run        = run_q;
   assign duty       = duty_q;
   assign delays     = delays_q;
   assign runStart   = runstart_q;
   assign protoError = perr_q;
endmodule

// File: tb/tb_host_bus_receiver.sv
// tb_host_bus_receiver: scoreboard bench; stimulus pushes expected register
// snapshots tagged with the cycle they must appear, a negedge monitor compares.
`timescale 1ns/1ps
module tb_host_bus_receiver;
   localparam int NS = 37;
   localparam int DW = 6*NS;
   logic          clk10 = 1'b0;
   logic          reset_n = 1'b0;
   logic          sync = 1'b0;
   logic          address = 1'b0;
   logic [5:0]    data = '0;
   logic          run;
   logic [5:0]    duty;
   logic [DW-1:0] delays;
   logic          runStart;
   logic          protoError;

   host_bus_receiver #(.NUM_SPEAKERS(NS), .DELAY_BASE(6'h10), .DUTY_RESET(6'h08)) dut (
      .clk10(clk10), .reset_n(reset_n), .sync(sync), .address(address), .data(data),
      .run(run), .duty(duty), .delays(delays), .runStart(runStart), .protoError(protoError)
   );

   always #50 clk10 = ~clk10;

   typedef struct {
      int            cyc;
      logic          run;
      logic [5:0]    duty;
      logic [DW-1:0] dly;
      logic          rs;
      logic          perr;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   rs_seen = 0;

   // reference model: register file plus "address pending" flag
   logic       m_run;
   logic [5:0] m_duty;
   logic [5:0] m_dly[NS];
   logic [5:0] m_addr;
   logic       m_perr;
   bit         m_pend;
   int         m_rs = 0;

   always @(posedge clk10) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
      end
   endtask

   always @(negedge clk10) begin
      if (runStart === 1'b1) rs_seen++;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         chk("stale_entry", 256'(q[0].cyc), 256'(cyc));
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         chk("run", 256'(run), 256'(e.run));
         chk("duty", 256'(duty), 256'(e.duty));
         chk("delays", 256'(delays), 256'(e.dly));
         chk("runStart", 256'(runStart), 256'(e.rs));
         chk("protoError", 256'(protoError), 256'(e.perr));
      end
   end

   task automatic m_reset();
      m_run = 0; m_duty = 6'h08; m_perr = 0; m_pend = 0; m_addr = 0;
      for (int n = 0; n < NS; n++) m_dly[n] = 0;
   endtask

   task automatic m_phase(input bit a, input logic [5:0] v, output logic rs);
      rs = 0;
      if (a) begin
         if (m_pend) m_perr = 1;
         m_pend = 1;
         m_addr = v;
      end else if (!m_pend) begin
         m_perr = 1;
      end else begin
         m_pend = 0;
         if (m_addr == 0) m_perr = 0;
         else if (m_addr == 1) begin
            if (!m_run && v[0]) begin rs = 1; m_rs++; end
            m_run = v[0];
         end
         else if (m_addr == 2) m_duty = v;
         else if (int'(m_addr) >= 16 && int'(m_addr) < 16 + NS) m_dly[int'(m_addr) - 16] = v;
         else m_perr = 1;
      end
   endtask

   task automatic push(input int c, input logic rs);
      exp_t x;
      x.cyc = c; x.run = m_run; x.duty = m_duty; x.rs = rs; x.perr = m_perr;
      for (int n = 0; n < NS; n++) x.dly[6*n +: 6] = m_dly[n];
      q.push_back(x);
   endtask

   // entered #1 after an edge with sync low; sync rises one cycle after data settles
   task automatic phase(input bit a, input logic [5:0] v, input int h);
      logic rs;
      address = a; data = v;
      @(posedge clk10); #1 sync = 1;
      m_phase(a, v, rs);
      push(cyc + 3, rs);
      repeat (h) @(posedge clk10);
      #1 sync = 0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [5:0] v);
      phase(1, a, 1);
      phase(0, v, 1);
   endtask

   task automatic drain();
      repeat (5) @(posedge clk10);
      #1;
   endtask

   task automatic do_reset(input int n);
      drain();
      reset_n = 0;
      m_reset();
      push(cyc, 0);
      repeat (n) begin
         @(posedge clk10); #1 sync = ~sync;
         push(cyc, 0);
      end
      @(posedge clk10); #1 sync = 0;
      push(cyc, 0);
      @(posedge clk10); #1 reset_n = 1;
      push(cyc, 0);
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] a;
      int r;
      m_reset();
      @(posedge clk10); #1;
      do_reset(6);
      wr(6'h02, 6'h08); wr(6'h10, 6'h00); wr(6'h11, 6'h01); wr(6'h12, 6'h0F);
      wr(6'h01, 6'h01); wr(6'h01, 6'h01); wr(6'h01, 6'h00); wr(6'h01, 6'h01);
      wr(6'h00, 6'h00); phase(0, 6'h2A, 1);
      wr(6'h00, 6'h15); phase(1, 6'h11, 1); phase(1, 6'h12, 1); phase(0, 6'h05, 1);
      wr(6'h00, 6'h3F);
      wr(6'h35, 6'h3F); wr(6'h00, 6'h00); wr(6'h3F, 6'h3F); wr(6'h00, 6'h00);
      wr(6'h34, 6'h2B); wr(6'h02, 6'h3F);
      phase(1, 6'h10, 1);
      do_reset(1);
      phase(0, 6'h07, 1);
      wr(6'h11, 6'h22);
      wr(6'h00, 6'h00);
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         a = (r == 0) ? 6'h00 : (r < 3) ? 6'(r) : (r < 8) ? 6'h10 + 6'($urandom_range(0, NS - 1))
                                                 : 6'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) phase(1'($urandom_range(0, 1)), 6'($urandom), $urandom_range(1, 3));
         else begin
            phase(1, a, $urandom_range(1, 3));
            phase(0, 6'($urandom), $urandom_range(1, 3));
         end
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk10);
            #1;
         end
         if (i == 200) do_reset(2);
      end
      drain();
      chk("queue_empty", 256'(q.size()), 256'(0));
      chk("runStart_total", 256'(rs_seen), 256'(m_rs));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
